rle_dec: RTL and testbench



---
 rtl/rle_dec.sv | 121 ++++++++++++
 tb/tb_rle_dec.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rle_dec.sv
// Run-length decoder: expands 24-bit run words {bit, length[22:0]} into a
// bit stream and packs it MSB-first into bytes for the HPS-read output FIFO.
module rle_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic        recv_ready,
  input  logic        send_ready,
  input  logic [23:0] in_data,
  input  logic        end_of_stream,
  output logic        rd_req,
  output logic [7:0]  out_data,
  output logic        wr_req,
  output logic        flushed
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  logic [1:0]  state_q,     state_d;
  logic        cur_bit_q,   cur_bit_d;
  logic [22:0] remaining_q, remaining_d;
  logic [7:0]  shift_q,     shift_d;
  logic [3:0]  nbits_q,     nbits_d;
  logic [7:0]  out_data_q,  out_data_d;

  // Values the RUN state would commit this cycle.
  logic [7:0]  run_shift;
  logic [3:0]  run_nbits;
  logic [22:0] run_remaining;

  always_comb begin
    run_shift     = {shift_q[6:0], cur_bit_q};
    run_nbits     = nbits_q + 4'd1;
    run_remaining = (remaining_q != 23'd0) ? remaining_q - 23'd1 : 23'd0;
  end

  always_comb begin
    // NOTE: every signal gets a default up front so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cur_bit_d   = cur_bit_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    nbits_d     = nbits_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        // A waiting input word always wins over a flush request.
        if (recv_ready) begin
          state_d = ST_LOAD;
        end else if (end_of_stream && (nbits_q != 4'd0)) begin
          out_data_d  = shift_q << (4'd8 - nbits_q);
          remaining_d = 23'd0;
          state_d     = ST_EMIT;
        end
      end

      ST_LOAD: begin
        cur_bit_d   = in_data[23];
        remaining_d = in_data[22:0];
        state_d     = (in_data[22:0] == 23'd0) ? ST_IDLE : ST_RUN;
      end

      ST_RUN: begin
        shift_d     = run_shift;
        nbits_d     = run_nbits;
        remaining_d = run_remaining;
        if (run_nbits == 4'd8) begin
          out_data_d = run_shift;
          state_d    = ST_EMIT;
        end else if (run_remaining == 23'd0) begin
          state_d = ST_IDLE;
        end
      end

      ST_EMIT: begin
        // The byte stays on out_data until the output FIFO accepts it.
        if (send_ready) begin
          nbits_d = 4'd0;
          shift_d = 8'd0;
          state_d = (remaining_q != 23'd0) ? ST_RUN : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_bit_q   <= 1'b0;
      remaining_q <= 23'd0;
      shift_q     <= 8'd0;
      nbits_q     <= 4'd0;
      out_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cur_bit_q   <= cur_bit_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      nbits_q     <= nbits_d;
      out_data_q  <= out_data_d;
    end
  end

  // Strobes are gated by rst so nothing is pushed or popped while in reset.
  always_comb begin
    rd_req   = !rst && (state_q == ST_IDLE) && recv_ready;
    wr_req   = !rst && (state_q == ST_EMIT) && send_ready;
    flushed  = !rst && (state_q == ST_IDLE) && !recv_ready && end_of_stream
               && (nbits_q == 4'd0);
    out_data = out_data_q;
  end

endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec: a FIFO model feeds run words, expected bytes go
// to a scoreboard queue and are compared whenever the decoder pushes a byte.
module tb_rle_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recv_ready = 1'b0;
  logic        send_ready = 1'b1;
  logic [23:0] in_data = 24'd0;
  logic        end_of_stream = 1'b0;
  logic        rd_req;
  logic [7:0]  out_data;
  logic        wr_req;
  logic        flushed;

  rle_dec dut (
    .clk           (clk),
    .rst           (rst),
    .recv_ready    (recv_ready),
    .send_ready    (send_ready),
    .in_data       (in_data),
    .end_of_stream (end_of_stream),
    .rd_req        (rd_req),
    .out_data      (out_data),
    .wr_req        (wr_req),
    .flushed       (flushed)
  );

  always #5 clk = ~clk;

  logic [23:0] in_q[$];
  logic [7:0]  exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_rd_cyc = 0;
  int last_lat = 0;

  // Input FIFO with show-ahead off: q is valid the cycle after rd_req.
  always @(posedge clk) begin
    if (rd_req && in_q.size() != 0) in_data <= in_q.pop_front();
  end

  always @(negedge clk) begin
    #1 recv_ready = (in_q.size() != 0);
  end

  // Monitor samples well away from the rising edge.
  always @(negedge clk) begin
    #3;
    cyc++;
    if (rd_req) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (wr_req) begin
      wr_cnt++;
      last_lat = cyc - last_rd_cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_byte observed=%02h expected=none", out_data);
      end
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (out_data === e) else begin
          errors++;
          $error("FAIL byte observed=%02h expected=%02h", out_data, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [23:0] w);
    in_q.push_back(w);
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int rd0;
    int wr0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flushed", flushed, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full byte of ones, with latency from rd_req to wr_req.
    push_word(24'h800008);
    exp_q.push_back(8'hFF);
    wait_drain("t1", 50);
    check("t1_latency", last_lat, 10);
    end_of_stream = 1'b1;
    repeat (2) @(negedge clk);
    #2 check("t1_flushed", flushed, 1);
    end_of_stream = 1'b0;
    @(negedge clk);

    // Two words completing one byte.
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_word(24'h800003);
    push_word(24'h000005);
    exp_q.push_back(8'hE0);
    wait_drain("t2", 60);
    check("t2_rd_count", rd_cnt - rd0, 2);
    check("t2_wr_count", wr_cnt - wr0, 1);

    // Partial byte flushed at end of stream, then no re-emit.
    push_word(24'h800004);
    exp_q.push_back(8'hF0);
    repeat (12) @(negedge clk);
    end_of_stream = 1'b1;
    wait_drain("t3", 40);
    #2 check("t3_flushed", flushed, 1);
    wr0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("t3_no_reemit", wr_cnt - wr0, 0);
    end_of_stream = 1'b0;
    @(negedge clk);

    // Zero-length word in the middle is consumed silently.
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_word(24'h800002);
    push_word(24'h000000);
    push_word(24'h000006);
    exp_q.push_back(8'hC0);
    wait_drain("t4", 60);
    check("t4_rd_count", rd_cnt - rd0, 3);
    check("t4_wr_count", wr_cnt - wr0, 1);

    // Backpressure across a 20-bit run.
    send_ready = 1'b0;
    wr0 = wr_cnt;
    push_word(24'h800014);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    repeat (15) @(negedge clk);
    check("t5_stall1_wr", wr_cnt - wr0, 0);
    check("t5_stall1_data", out_data, 8'hFF);
    send_ready = 1'b1;
    @(negedge clk);
    send_ready = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_stall2_wr", wr_cnt - wr0, 1);
    check("t5_stall2_data", out_data, 8'hFF);
    send_ready = 1'b1;
    wait_drain("t5", 40);
    exp_q.push_back(8'hF0);
    end_of_stream = 1'b1;
    wait_drain("t5_flush", 40);
    end_of_stream = 1'b0;
    @(negedge clk);

    // Reset in the middle of a run drops the partial byte.
    push_word(24'h800010);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_rd_req", rd_req, 0);
    check("t6_rst_wr_req", wr_req, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_flushed", flushed, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr0 = wr_cnt;
    push_word(24'h000008);
    exp_q.push_back(8'h00);
    wait_drain("t6", 50);
    check("t6_wr_count", wr_cnt - wr0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
